// File: rtl/branch_ctrl.sv
// branch_ctrl: branch prediction and resolution controller for the RV32I pipeline.
// A table of 2-bit saturating counters predicts in IF. EX resolves the branch
// against the prediction that travelled with it and trains the table. On a
// misprediction it flushes IF/ID and ID/EX and holds a fetch redirect until
// fetch accepts it. It also keeps branch and misprediction counts.
module branch_ctrl #(
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_br_valid,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        ex_br_en,
  input  logic        fetch_ready,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int BHT_SIZE = 1 << BHT_IDX_W;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             bht_q [BHT_SIZE];
  logic [1:0]             bht_d [BHT_SIZE];
  logic [31:0]            redirect_pc_q, redirect_pc_d;
  logic [31:0]            br_count_q, br_count_d;
  logic [31:0]            mispred_count_q, mispred_count_d;

  logic [BHT_IDX_W-1:0]   if_idx_s;
  logic [BHT_IDX_W-1:0]   ex_idx_s;
  logic                   resolve_s;
  logic                   mispredict_s;
  logic [31:0]            correct_pc_s;
  logic                   in_redirect_s;
  logic                   unused_s;

  // Word-aligned PCs: bits [1:0] and the bits above the index never select an entry.
  assign if_idx_s = if_pc[BHT_IDX_W+1:2];
  assign ex_idx_s = ex_pc[BHT_IDX_W+1:2];
  assign unused_s = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

  // Resolve once, on the first non-stalled EX cycle; wrong-path branches during a redirect are ignored.
  assign in_redirect_s = (state_q == REDIRECT);
  assign resolve_s     = ex_br_valid & ~ex_stall & ~in_redirect_s;
  assign mispredict_s  = resolve_s & (ex_br_en != ex_pred_taken);
  assign correct_pc_s  = ex_br_en ? ex_target : (ex_pc + 32'd4);

  // Prediction reads the registered table only, so a same-cycle training write is not bypassed.
  assign if_pred_taken = bht_q[if_idx_s][1];

  assign redirect      = in_redirect_s;
  assign flush_if_id   = mispredict_s | in_redirect_s;
  assign flush_id_ex   = mispredict_s | in_redirect_s;
  assign redirect_pc   = redirect_pc_q;
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

  // Next redirect state and redirect target.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (mispredict_s) begin
          state_d       = REDIRECT;
          redirect_pc_d = correct_pc_s;
        end else begin
          state_d       = IDLE;
        end
      end
      REDIRECT: begin
        if (fetch_ready) begin
          state_d = IDLE;
        end else begin
          state_d = REDIRECT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating counter update for the resolving branch's entry.
  always_comb begin
    bht_d = bht_q;
    if (resolve_s) begin
      if (ex_br_en) begin
        if (bht_q[ex_idx_s] != 2'b11) begin
          bht_d[ex_idx_s] = bht_q[ex_idx_s] + 2'd1;
        end else begin
          bht_d[ex_idx_s] = 2'b11;
        end
      end else begin
        if (bht_q[ex_idx_s] != 2'b00) begin
          bht_d[ex_idx_s] = bht_q[ex_idx_s] - 2'd1;
        end else begin
          bht_d[ex_idx_s] = 2'b00;
        end
      end
    end else begin
      bht_d = bht_q;
    end
  end

  // Statistics counters; both wrap naturally at 2^32.
  always_comb begin
    if (resolve_s) begin
      br_count_d = br_count_q + 32'd1;
    end else begin
      br_count_d = br_count_q;
    end
    if (mispredict_s) begin
      mispred_count_d = mispred_count_q + 32'd1;
    end else begin
      mispred_count_d = mispred_count_q;
    end
  end

  // Control and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      redirect_pc_q   <= 32'd0;
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      redirect_pc_q   <= redirect_pc_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // Flop-based history table so every entry returns to CNT_INIT on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BHT_SIZE; k++) begin
        bht_q[k] <= CNT_INIT;
      end
    end else begin
      bht_q <= bht_d;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: a table of per-cycle stimulus records
// with expected outputs, checked through a scoreboard queue, plus a
// hand-written reset-during-redirect sequence.
module tb_branch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_br_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        ex_br_en;
  logic        fetch_ready;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  branch_ctrl #(.BHT_IDX_W(6), .CNT_INIT(2'b01)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_br_valid   (ex_br_valid),
    .ex_stall      (ex_stall),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_br_en      (ex_br_en),
    .fetch_ready   (fetch_ready),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  typedef struct packed {
    logic        pred;
    logic        fl_if_id;
    logic        fl_id_ex;
    logic        red;
    logic [31:0] rpc;
    logic [31:0] brc;
    logic [31:0] mpc;
  } out_t;

  typedef struct {
    logic        valid;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pt;
    logic        en;
    logic        fr;
    logic [31:0] ifpc;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb_q[$];
  int   n_vec;
  int   n_err;

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk_out(logic pred, logic fl, logic red, logic [31:0] rpc,
                                  logic [31:0] brc, logic [31:0] mpc);
    out_t o;
    o.pred     = pred;
    o.fl_if_id = fl;
    o.fl_id_ex = fl;
    o.red      = red;
    o.rpc      = rpc;
    o.brc      = brc;
    o.mpc      = mpc;
    return o;
  endfunction

  function automatic vec_t mk(logic valid, logic stall, logic [31:0] pc, logic [31:0] tgt,
                              logic pt, logic en, logic fr, logic [31:0] ifpc, out_t exp);
    vec_t v;
    v.valid = valid;
    v.stall = stall;
    v.pc    = pc;
    v.tgt   = tgt;
    v.pt    = pt;
    v.en    = en;
    v.fr    = fr;
    v.ifpc  = ifpc;
    v.exp   = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ex_br_valid   = v.valid;
    ex_stall      = v.stall;
    ex_pc         = v.pc;
    ex_target     = v.tgt;
    ex_pred_taken = v.pt;
    ex_br_en      = v.en;
    fetch_ready   = v.fr;
    if_pc         = v.ifpc;
    sb_q.push_back(v.exp);
  endtask

  task automatic check_pop(input string name);
    out_t act;
    out_t exp;
    act.pred     = if_pred_taken;
    act.fl_if_id = flush_if_id;
    act.fl_id_ex = flush_id_ex;
    act.red      = redirect;
    act.rpc      = redirect_pc;
    act.brc      = br_count;
    act.mpc      = mispred_count;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp = sb_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got pred=%0b fl=%0b/%0b red=%0b rpc=%h br=%0d mp=%0d, want pred=%0b fl=%0b/%0b red=%0b rpc=%h br=%0d mp=%0d",
                 name, act.pred, act.fl_if_id, act.fl_id_ex, act.red, act.rpc, act.brc, act.mpc,
                 exp.pred, exp.fl_if_id, exp.fl_id_ex, exp.red, exp.rpc, exp.brc, exp.mpc);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100,
             mk_out(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_pop("reset_state");
    rst_n = 1'b1;

    // Per-cycle table: mispredict taken, correct taken x3 with saturation,
    // not-taken train, wrap-around mispredict with slow fetch, stalled branch.
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b1, 32'h100,      mk_out(1'b0, 1'b0, 1'b0, 32'h0,   32'd0, 32'd0)));
    vecs.push_back(mk(1'b1, 1'b0, 32'h100,      32'h80,   1'b0, 1'b1, 1'b1, 32'h100,      mk_out(1'b0, 1'b1, 1'b0, 32'h0,   32'd0, 32'd0)));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b1, 32'h100,      mk_out(1'b1, 1'b1, 1'b1, 32'h80,  32'd1, 32'd1)));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b1, 32'h100,      mk_out(1'b1, 1'b0, 1'b0, 32'h80,  32'd1, 32'd1)));
    vecs.push_back(mk(1'b1, 1'b0, 32'h100,      32'h80,   1'b1, 1'b1, 1'b1, 32'h100,      mk_out(1'b1, 1'b0, 1'b0, 32'h80,  32'd1, 32'd1)));
    vecs.push_back(mk(1'b1, 1'b0, 32'h100,      32'h80,   1'b1, 1'b1, 1'b1, 32'h100,      mk_out(1'b1, 1'b0, 1'b0, 32'h80,  32'd2, 32'd1)));
    vecs.push_back(mk(1'b1, 1'b0, 32'h100,      32'h80,   1'b1, 1'b1, 1'b1, 32'h100,      mk_out(1'b1, 1'b0, 1'b0, 32'h80,  32'd3, 32'd1)));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b1, 32'h100,      mk_out(1'b1, 1'b0, 1'b0, 32'h80,  32'd4, 32'd1)));
    vecs.push_back(mk(1'b1, 1'b0, 32'h100,      32'h80,   1'b0, 1'b0, 1'b1, 32'h100,      mk_out(1'b1, 1'b0, 1'b0, 32'h80,  32'd4, 32'd1)));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b1, 32'h100,      mk_out(1'b1, 1'b0, 1'b0, 32'h80,  32'd5, 32'd1)));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFFFFFC, 32'h1234, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, mk_out(1'b0, 1'b1, 1'b0, 32'h80,  32'd5, 32'd1)));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, mk_out(1'b0, 1'b1, 1'b1, 32'h0,   32'd6, 32'd2)));
    vecs.push_back(mk(1'b1, 1'b0, 32'h100,      32'h80,   1'b1, 1'b0, 1'b0, 32'h100,      mk_out(1'b1, 1'b1, 1'b1, 32'h0,   32'd6, 32'd2)));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b0, 32'h100,      mk_out(1'b1, 1'b1, 1'b1, 32'h0,   32'd6, 32'd2)));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b1, 32'h100,      mk_out(1'b1, 1'b1, 1'b1, 32'h0,   32'd6, 32'd2)));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, mk_out(1'b0, 1'b0, 1'b0, 32'h0,   32'd6, 32'd2)));
    for (int s = 0; s < 5; s++) begin
      vecs.push_back(mk(1'b1, 1'b1, 32'h104,    32'h200,  1'b0, 1'b1, 1'b1, 32'h104,      mk_out(1'b0, 1'b0, 1'b0, 32'h0,   32'd6, 32'd2)));
    end
    vecs.push_back(mk(1'b1, 1'b0, 32'h104,      32'h200,  1'b0, 1'b1, 1'b1, 32'h104,      mk_out(1'b0, 1'b1, 1'b0, 32'h0,   32'd6, 32'd2)));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b1, 32'h104,      mk_out(1'b1, 1'b1, 1'b1, 32'h200, 32'd7, 32'd3)));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 1'b1, 32'h104,      mk_out(1'b1, 1'b0, 1'b0, 32'h200, 32'd7, 32'd3)));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check_pop($sformatf("vec%0d", i));
    end

    // Mispredict into REDIRECT with fetch stalled, then reset mid-redirect.
    @(posedge clk);
    #1;
    drive(mk(1'b1, 1'b0, 32'h108, 32'h300, 1'b0, 1'b1, 1'b0, 32'h104,
             mk_out(1'b1, 1'b1, 1'b0, 32'h200, 32'd7, 32'd3)));
    @(negedge clk);
    check_pop("pre_rst_detect");
    @(posedge clk);
    #1;
    drive(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h104,
             mk_out(1'b1, 1'b1, 1'b1, 32'h300, 32'd8, 32'd4)));
    @(negedge clk);
    check_pop("pre_rst_redirect");
    #2;
    rst_n = 1'b0;
    sb_q.push_back(mk_out(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0));
    #1;
    check_pop("async_rst_mid_redirect");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back(mk_out(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0));
    check_pop("post_rst_idle");
    for (int k = 0; k < 64; k++) begin
      if_pc = 32'(k) << 2;
      #1;
      sb_q.push_back(mk_out(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 32'd0));
      check_pop($sformatf("post_rst_pred_idx%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
